// File: rtl/ceff_reader.sv
// Drain side of a capture register: takes each captured word once, buffers it
// in a show-ahead FIFO, streams it out on valid/ready and acks the capture.
module ceff_reader #(
  parameter int SIZE        = 1,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SIZE-1:0]            cap_data_i,
  input  logic                       cap_valid_i,
  output logic                       cap_ack_o,
  output logic [SIZE-1:0]            m_data_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       err_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = $clog2(ACK_TIMEOUT+1);

  typedef enum logic {IDLE, WAIT_CLR} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            ack_nx, err_nx, push, pop;
  logic [SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;

  assign pop       = m_valid_o && m_ready_i;
  assign m_valid_o = (level != '0);
  assign m_data_o  = m_valid_o ? mem[rd_ptr] : '0;
  assign level_o   = level;

  // Fullness is judged on the current level, so a same-cycle pop never
  // makes room for a push.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ack_nx   = 1'b0;
    err_nx   = err_o;
    push     = 1'b0;
    case (state)
      IDLE: begin
        if (cap_valid_i && (level < LW'(DEPTH))) begin
          push     = 1'b1;
          ack_nx   = 1'b1;
          state_nx = WAIT_CLR;
        end
      end
      WAIT_CLR: begin
        if (!cap_valid_i) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CW'(ACK_TIMEOUT-1)) begin
          err_nx = 1'b1;
          ack_nx = 1'b1;
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_ack_o <= 1'b0;
      err_o     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      cap_ack_o <= ack_nx;
      err_o     <= err_nx;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cap_data_i;
  end
endmodule

// File: tb/tb_ceff_reader.sv
// Directed bench for ceff_reader: cycle table for reset, single take and
// push/pop-at-level-2, plus sequences for full FIFO, ack timeout and mid reset.
module tb_ceff_reader;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cap_data_i;
  logic       cap_valid_i;
  logic       cap_ack_o;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic [2:0] level_o;
  logic       err_o;

  int tests = 0;
  int fails = 0;
  logic [7:0] out_q[$];

  ceff_reader #(.SIZE(8), .DEPTH(4), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .cap_data_i(cap_data_i), .cap_valid_i(cap_valid_i),
    .cap_ack_o(cap_ack_o), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .level_o(level_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // A handshake visible at the falling edge completes on the next rising edge.
  always @(negedge clk) if (m_valid_o && m_ready_i) out_q.push_back(m_data_o);

  typedef struct {
    logic       rst, v, rdy;
    logic [7:0] d;
    logic       ack, val;
    logic [7:0] data;
    logic [2:0] lvl;
    logic       err;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a word, expect (or not) an ack one edge later, clear if acked.
  task automatic take(input logic [7:0] d, input logic exp_ack, input string name);
    cap_valid_i = 1'b1; cap_data_i = d;
    step();
    chk(name, cap_ack_o, exp_ack);
    if (cap_ack_o) begin
      cap_valid_i = 1'b0;
      step();
    end
  endtask

  initial begin
    //            rst  v    rdy  d      ack  val  data   lvl  err
    tbl[0]  = '{1'b1,1'b1,1'b0,8'hFF, 1'b0,1'b0,8'h00, 3'd0,1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b0,8'hFF, 1'b0,1'b0,8'h00, 3'd0,1'b0};
    tbl[2]  = '{1'b1,1'b1,1'b0,8'hFF, 1'b0,1'b0,8'h00, 3'd0,1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b1,8'hA5, 1'b1,1'b1,8'hA5, 3'd1,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b1,8'h00, 1'b0,1'b0,8'h00, 3'd0,1'b0};
    tbl[5]  = '{1'b0,1'b1,1'b0,8'h11, 1'b1,1'b1,8'h11, 3'd1,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'h11, 3'd1,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b0,8'h22, 1'b1,1'b1,8'h11, 3'd2,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'h11, 3'd2,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b1,8'h33, 1'b1,1'b1,8'h22, 3'd2,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b1,8'h00, 1'b0,1'b1,8'h33, 3'd1,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b1,8'h00, 1'b0,1'b0,8'h00, 3'd0,1'b0};

    reset = 1'b1; cap_valid_i = 1'b0; cap_data_i = '0; m_ready_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      reset = tbl[i].rst; cap_valid_i = tbl[i].v; m_ready_i = tbl[i].rdy;
      cap_data_i = tbl[i].d;
      step();
      chk($sformatf("row%0d ack", i),   cap_ack_o, tbl[i].ack);
      chk($sformatf("row%0d valid", i), m_valid_o, tbl[i].val);
      chk($sformatf("row%0d data", i),  m_data_o,  tbl[i].data);
      chk($sformatf("row%0d level", i), level_o,   tbl[i].lvl);
      chk($sformatf("row%0d err", i),   err_o,     tbl[i].err);
    end

    // Full FIFO holds the fifth word until a pop makes room.
    cap_valid_i = 1'b0; m_ready_i = 1'b0; out_q.delete();
    for (int i = 1; i <= 4; i++) take(8'(i), 1'b1, $sformatf("fill ack%0d", i));
    cap_valid_i = 1'b1; cap_data_i = 8'h05;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full no ack", cap_ack_o, 1'b0);
      chk("full level", level_o, 3'd4);
    end
    m_ready_i = 1'b1;
    for (int i = 0; i < 20 && out_q.size() < 5; i++) begin
      step();
      if (cap_ack_o) cap_valid_i = 1'b0;
    end
    chk("drain count", out_q.size(), 5);
    for (int i = 0; i < 5 && i < out_q.size(); i++)
      chk($sformatf("drain order%0d", i), out_q[i], 8'(i + 1));
    m_ready_i = 1'b0; cap_valid_i = 1'b0;
    step();
    chk("drain empty", level_o, 3'd0);

    // Capture never clears: err and a single re-ack on the 16th waiting edge.
    cap_valid_i = 1'b1; cap_data_i = 8'h77;
    step();
    chk("stuck take ack", cap_ack_o, 1'b1);
    for (int i = 1; i <= 18; i++) begin
      step();
      chk($sformatf("stuck ack e%0d", i), cap_ack_o, (i == 16) ? 1'b1 : 1'b0);
      chk($sformatf("stuck err e%0d", i), err_o, (i >= 16) ? 1'b1 : 1'b0);
    end
    chk("stuck no dup", level_o, 3'd1);
    cap_valid_i = 1'b0; m_ready_i = 1'b1;
    step(); step();
    chk("err sticky", err_o, 1'b1);
    chk("stuck drained", level_o, 3'd0);

    // Reset mid-operation: level 3 with the FSM in WAIT_CLR.
    m_ready_i = 1'b0;
    take(8'hC1, 1'b1, "mid ack1");
    take(8'hC2, 1'b1, "mid ack2");
    cap_valid_i = 1'b1; cap_data_i = 8'hC3;
    step();
    chk("mid level3", level_o, 3'd3);
    reset = 1'b1; cap_valid_i = 1'b0;
    step();
    chk("mid rst ack", cap_ack_o, 1'b0);
    chk("mid rst valid", m_valid_o, 1'b0);
    chk("mid rst data", m_data_o, 8'h00);
    chk("mid rst level", level_o, 3'd0);
    chk("mid rst err", err_o, 1'b0);
    reset = 1'b0; m_ready_i = 1'b1;
    cap_valid_i = 1'b1; cap_data_i = 8'h3C;
    step();
    chk("post ack", cap_ack_o, 1'b1);
    chk("post valid", m_valid_o, 1'b1);
    chk("post data", m_data_o, 8'h3C);
    chk("post level", level_o, 3'd1);
    cap_valid_i = 1'b0;
    step();
    chk("post drained", level_o, 3'd0);
    chk("post ack drop", cap_ack_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
